// File: rtl/vga_frame_signature.sv
// rtl/vga_frame_signature.sv - per-frame CRC-32 signature and geometry monitor for the VGA output path
//
// Ports:
//   clk, rst_n        pixel clock, asynchronous active-low reset
//   arm, abort        1-cycle control pulses (start capture / return to idle)
//   vs, hblnk, vblnk  video timing; a frame boundary is the falling edge of vs
//   r, g, b           pixel colour, hashed as {r,g,b}
//   exp_sig           expected signature of the frame being posted
//   busy, done        capture in progress / capture sequence complete (levels)
//   sig_valid         1-cycle pulse with signature, frame_idx, match, geom_err
module vga_frame_signature #(
  parameter int COLOR_W  = 4,
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int FRAMES   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic               abort,
  input  logic               vs,
  input  logic               hblnk,
  input  logic               vblnk,
  input  logic [COLOR_W-1:0] r,
  input  logic [COLOR_W-1:0] g,
  input  logic [COLOR_W-1:0] b,
  input  logic [31:0]        exp_sig,
  output logic               busy,
  output logic               sig_valid,
  output logic [31:0]        signature,
  output logic [7:0]         frame_idx,
  output logic               match,
  output logic               geom_err,
  output logic               done
);

  localparam int          PIX_W      = 3 * COLOR_W;
  localparam logic [31:0] POLY       = 32'h04C1_1DB7;
  localparam logic [20:0] PIX_EXP    = 21'(H_ACTIVE * V_ACTIVE);
  localparam logic [10:0] LINE_EXP   = 11'(V_ACTIVE);
  localparam logic [7:0]  LAST_FRAME = 8'(FRAMES - 1);

  typedef enum logic [1:0] {IDLE, SYNC, ACCUM, DONE} state_t;

  state_t      state;
  logic        vs_d;
  logic        hblnk_d;
  logic [31:0] crc;
  logic [20:0] pix_cnt;
  logic [10:0] line_cnt;
  logic [7:0]  frame_cnt;

  logic             vs_fall;
  logic             active;
  logic             line_start;
  logic [PIX_W-1:0] pix;

  assign vs_fall    = vs_d & ~vs;
  assign active     = ~hblnk & ~vblnk;
  assign line_start = hblnk_d & ~hblnk & ~vblnk;
  assign pix        = {r, g, b};

  // Bit-serial CRC-32, MSB of the pixel word first, unrolled over one pixel.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [PIX_W-1:0] d);
    logic [31:0] n;
    n = c;
    for (int i = PIX_W - 1; i >= 0; i--) begin
      if (n[31] ^ d[i]) n = {n[30:0], 1'b0} ^ POLY;
      else              n = {n[30:0], 1'b0};
    end
    return n;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vs_d      <= 1'b0;
      hblnk_d   <= 1'b0;
      crc       <= 32'hFFFF_FFFF;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      frame_cnt <= '0;
      busy      <= 1'b0;
      sig_valid <= 1'b0;
      signature <= '0;
      frame_idx <= '0;
      match     <= 1'b0;
      geom_err  <= 1'b0;
      done      <= 1'b0;
    end else begin
      vs_d      <= vs;
      hblnk_d   <= hblnk;
      sig_valid <= 1'b0;
      if (abort) begin
        // Results of the last completed frame stay visible; the partial frame is dropped.
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            // A vs edge in the arming cycle is deliberately not treated as a frame start.
            if (arm) begin
              state     <= SYNC;
              busy      <= 1'b1;
              done      <= 1'b0;
              frame_cnt <= '0;
            end
          end
          SYNC: begin
            if (vs_fall) begin
              crc      <= 32'hFFFF_FFFF;
              pix_cnt  <= '0;
              line_cnt <= '0;
              state    <= ACCUM;
            end
          end
          ACCUM: begin
            if (vs_fall) begin
              // Post the finished frame and restart accumulation on the same edge;
              // the pixel of the edge cycle itself is not hashed.
              sig_valid <= 1'b1;
              signature <= crc;
              match     <= (crc == exp_sig);
              geom_err  <= (pix_cnt != PIX_EXP) || (line_cnt != LINE_EXP);
              frame_idx <= frame_cnt;
              crc       <= 32'hFFFF_FFFF;
              pix_cnt   <= '0;
              line_cnt  <= '0;
              if (frame_cnt == LAST_FRAME) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                frame_cnt <= frame_cnt + 8'd1;
              end
            end else begin
              if (active) begin
                crc <= crc_step(crc, pix);
                if (pix_cnt != '1) pix_cnt <= pix_cnt + 21'd1;
              end
              if (line_start && (line_cnt != '1)) line_cnt <= line_cnt + 11'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_signature.sv
// tb/tb_vga_frame_signature.sv - scoreboard bench for vga_frame_signature with a reduced raster
module tb_vga_frame_signature;

  localparam int CW = 4;
  localparam int HA = 16;
  localparam int VA = 12;
  localparam int NF = 2;
  localparam int HT = 24;
  localparam int VB = 4;
  localparam int VT = VB + VA;
  localparam int PW = 3 * CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          vs = 1'b0;
  logic          hblnk = 1'b1;
  logic          vblnk = 1'b1;
  logic [CW-1:0] r = '0;
  logic [CW-1:0] g = '0;
  logic [CW-1:0] b = '0;
  logic [31:0]   exp_sig = '0;
  logic          busy;
  logic          sig_valid;
  logic [31:0]   signature;
  logic [7:0]    frame_idx;
  logic          match;
  logic          geom_err;
  logic          done;

  always #5 clk = ~clk;

  vga_frame_signature #(
    .COLOR_W(CW), .H_ACTIVE(HA), .V_ACTIVE(VA), .FRAMES(NF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .vs(vs), .hblnk(hblnk),
    .vblnk(vblnk), .r(r), .g(g), .b(b), .exp_sig(exp_sig), .busy(busy),
    .sig_valid(sig_valid), .signature(signature), .frame_idx(frame_idx),
    .match(match), .geom_err(geom_err), .done(done)
  );

  typedef struct packed {
    logic [31:0] sig;
    logic [7:0]  idx;
    logic        mt;
    logic        geom;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_sig = '0;
  logic [PW-1:0] fpix [VA][HA];
  int          line_len [VA];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: CRC-32 of the frame's active pixels as one MSB-first bit stream.
  function automatic logic [31:0] model_sig();
    bit          bits[$];
    logic [31:0] c;
    for (int v = 0; v < VA; v++)
      for (int h = 0; h < line_len[v]; h++)
        for (int k = PW - 1; k >= 0; k--) bits.push_back(fpix[v][h][k]);
    c = 32'hFFFF_FFFF;
    foreach (bits[i]) c = {c[30:0], 1'b0} ^ ((c[31] ^ bits[i]) ? 32'h04C1_1DB7 : 32'h0);
    return c;
  endfunction

  function automatic logic model_geom();
    int pcnt;
    int lcnt;
    pcnt = 0;
    lcnt = 0;
    for (int v = 0; v < VA; v++) begin
      pcnt += line_len[v];
      if (line_len[v] > 0) lcnt++;
    end
    return (pcnt != HA * VA) || (lcnt != VA);
  endfunction

  task automatic fill(input bit rnd, input logic [PW-1:0] val);
    for (int v = 0; v < VA; v++) begin
      line_len[v] = HA;
      for (int h = 0; h < HA; h++) fpix[v][h] = rnd ? PW'($urandom) : val;
    end
  endtask

  // One raster: blank lines with a vs pulse (falling at line 3), then VA active lines.
  task automatic drive_frame(input logic [31:0] e, input bit arm_fall);
    exp_sig = e;
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        vblnk = (v < VB);
        vs    = (v == 1) || (v == 2);
        if (v >= VB) hblnk = (h >= line_len[v-VB]);
        else         hblnk = (h >= HA);
        if (!hblnk && !vblnk) {r, g, b} = fpix[v-VB][h];
        else                  {r, g, b} = PW'($urandom);
        arm = arm_fall && (v == 3) && (h == 0);
        @(posedge clk); #1;
      end
    end
    arm = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  // kind: 0 all-zero, 1 frame 1 has one red pixel, 2 random, 3 frame 1 short line
  task automatic run_capture(input int kind, input bit arm_at_edge);
    logic [31:0] e [NF];
    logic [31:0] xs [NF];
    logic        gm [NF];
    exp_t        ent;
    if (arm_at_edge) begin
      fill(1'b1, '0);
      drive_frame(32'h0, 1'b1);
      check("busy_after_edge_arm", {31'b0, busy}, 32'd1);
    end else begin
      pulse_arm();
    end
    for (int f = 0; f < NF; f++) begin
      if (kind == 0 || kind == 1) fill(1'b0, '0);
      else                        fill(1'b1, '0);
      if (kind == 1 && f == 1) fpix[5][7] = 12'hF00;
      if (kind == 3 && f == 1) line_len[4] = HA - 1;
      e[f]  = model_sig();
      gm[f] = model_geom();
      xs[f] = e[f];
      if (kind == 1 && f == 1) xs[f] = e[0];
      if (kind == 2 && $urandom_range(1) == 1) xs[f] = e[f] ^ (32'h1 << $urandom_range(31));
      if (f > 0) begin
        ent = '{sig: e[f-1], idx: 8'(f-1), mt: (e[f-1] == xs[f-1]), geom: gm[f-1]};
        sb.push_back(ent);
      end
      drive_frame((f > 0) ? xs[f-1] : 32'h0, 1'b0);
    end
    ent = '{sig: e[NF-1], idx: 8'(NF-1), mt: (e[NF-1] == xs[NF-1]), geom: gm[NF-1]};
    sb.push_back(ent);
    fill(1'b1, '0);
    drive_frame(xs[NF-1], 1'b0);
    check("done_after_capture", {31'b0, done}, 32'd1);
    check("busy_after_capture", {31'b0, busy}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && sig_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_sig_valid actual=1 required=0 idx=%0d", frame_idx);
      end else begin
        mon_e = sb.pop_front();
        check("signature", signature, mon_e.sig);
        check("frame_idx", {24'b0, frame_idx}, {24'b0, mon_e.idx});
        check("match", {31'b0, match}, {31'b0, mon_e.mt});
        check("geom_err", {31'b0, geom_err}, {31'b0, mon_e.geom});
        last_sig = mon_e.sig;
      end
    end
  end

  initial begin
    fill(1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_sig_valid", {31'b0, sig_valid}, 32'd0);
    check("rst_signature", signature, 32'd0);
    check("rst_frame_idx", {24'b0, frame_idx}, 32'd0);
    check("rst_match", {31'b0, match}, 32'd0);
    check("rst_geom_err", {31'b0, geom_err}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_capture(0, 1'b0);
    run_capture(1, 1'b0);
    for (int i = 0; i < 3; i++) run_capture(2, 1'b0);
    run_capture(3, 1'b0);

    // abort mid-frame 0: no post, results hold
    pulse_arm();
    fill(1'b1, '0);
    fork
      drive_frame(32'h0, 1'b0);
      begin
        repeat (VB * HT + 60) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_signature_hold", signature, last_sig);
      end
    join
    fill(1'b1, '0);
    drive_frame(32'h0, 1'b0);
    check("abort_done", {31'b0, done}, 32'd0);

    // arm coinciding with a vs falling edge from IDLE
    run_capture(2, 1'b1);

    // reset while accumulating
    pulse_arm();
    fill(1'b1, '0);
    fork
      drive_frame(32'h0, 1'b0);
      begin
        repeat (VB * HT + 80) @(posedge clk);
        #1;
        check("pre_reset_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_signature", signature, 32'd0);
        check("mid_rst_frame_idx", {24'b0, frame_idx}, 32'd0);
        check("mid_rst_match", {31'b0, match}, 32'd0);
        check("mid_rst_geom_err", {31'b0, geom_err}, 32'd0);
        check("mid_rst_done", {31'b0, done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    join
    fill(1'b1, '0);
    drive_frame(32'h0, 1'b0);
    check("post_reset_busy", {31'b0, busy}, 32'd0);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
